vga_timing_gen: RTL and testbench

Generates 640x480@60 Hz VGA raster timing from the pixel clock: current-pixel coordinates (DrawX, DrawY), display-enable (blank), active-low syncs, and frame/line markers. Every sprite, ROM and palette renderer downstream consumes these outputs. Renderers register their colour one cycle after seeing DrawX/DrawY, so the block also provides sync and enable outputs delayed by a parameterised number of cycles. This keeps the syncs aligned with rendered RGB at the DAC.

---
 rtl/vga_timing_pkg.sv | 18 +
 rtl/vga_timing_gen_if.sv | 19 +
 rtl/vga_sync_delay.sv | 29 ++
 rtl/vga_timing_gen.sv | 67 ++++++
 tb/tb_vga_timing_gen.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 defaults, total derivation and the shared coordinate type
package vga_timing_pkg;
   typedef logic [9:0] coord_t;
   localparam int H_VISIBLE_DEF = 640;
   localparam int H_FRONT_DEF   = 16;
   localparam int H_SYNC_DEF    = 96;
   localparam int H_BACK_DEF    = 48;
   localparam int V_VISIBLE_DEF = 480;
   localparam int V_FRONT_DEF   = 10;
   localparam int V_SYNC_DEF    = 2;
   localparam int V_BACK_DEF    = 33;
   function automatic int h_total(int vis, int fr, int sy, int bk);
      return vis + fr + sy + bk;
   endfunction
   function automatic int v_total(int vis, int fr, int sy, int bk);
      return vis + fr + sy + bk;
   endfunction
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bundle between the generator and its renderers
interface vga_timing_gen_if;
   logic                   pixel_en;
   vga_timing_pkg::coord_t DrawX;
   vga_timing_pkg::coord_t DrawY;
   logic                   blank;
   logic                   hs;
   logic                   vs;
   logic                   hs_d;
   logic                   vs_d;
   logic                   blank_d;
   logic                   line_start;
   logic                   frame_start;
   logic [7:0]             frame_count;
   modport master (input pixel_en, output DrawX, DrawY, blank, hs, vs, hs_d, vs_d, blank_d,
                   line_start, frame_start, frame_count);
   modport slave  (output pixel_en, input DrawX, DrawY, blank, hs, vs, hs_d, vs_d, blank_d,
                   line_start, frame_start, frame_count);
endinterface

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: fixed-depth shift register with per-bit reset value; depth 0 is a wire
module vga_sync_delay #(
   parameter int               DEPTH   = 1,
   parameter int               WIDTH   = 3,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             vga_clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   generate
      if (DEPTH == 0) begin : g_pass
         assign q = d;
      end else begin : g_sr
         logic [WIDTH-1:0] sr [DEPTH];
         // shift every clock so the delay matches the renderer pipeline, not pixel_en
         always_ff @(posedge vga_clk or negedge reset_n) begin
            if (!reset_n) begin
               for (int i = 0; i < DEPTH; i++) sr[i] <= RST_VAL;
            end else begin
               sr[0] <= d;
               for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
            end
         end
         assign q = sr[DEPTH-1];
      end
   endgenerate
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters, sync/blank decode, line/frame markers and frame counter
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_VISIBLE  = H_VISIBLE_DEF,
   parameter int H_FRONT    = H_FRONT_DEF,
   parameter int H_SYNC     = H_SYNC_DEF,
   parameter int H_BACK     = H_BACK_DEF,
   parameter int V_VISIBLE  = V_VISIBLE_DEF,
   parameter int V_FRONT    = V_FRONT_DEF,
   parameter int V_SYNC     = V_SYNC_DEF,
   parameter int V_BACK     = V_BACK_DEF,
   parameter int PIPE_DELAY = 1
) (
   input logic        vga_clk,
   input logic        reset_n,
   vga_timing_gen_if.master vga
);
   localparam int     H_TOTAL = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
   localparam int     V_TOTAL = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
   localparam coord_t H_LAST  = coord_t'(H_TOTAL - 1);
   localparam coord_t V_LAST  = coord_t'(V_TOTAL - 1);
   localparam coord_t H_VIS   = coord_t'(H_VISIBLE);
   localparam coord_t V_VIS   = coord_t'(V_VISIBLE);
   localparam coord_t HS_BEG  = coord_t'(H_VISIBLE + H_FRONT);
   localparam coord_t HS_END  = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam coord_t VS_BEG  = coord_t'(V_VISIBLE + V_FRONT);
   localparam coord_t VS_END  = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);
   coord_t     hc, vc;
   logic [7:0] fc;
   logic       h_wrap, v_wrap, hs, vs, blank;
   logic [2:0] dq;
   assign h_wrap = (hc == H_LAST);
   assign v_wrap = (vc == V_LAST);
   // raster position and completed-frame count advance only on enabled pixels
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         hc <= '0;
         vc <= '0;
         fc <= '0;
      end else if (vga.pixel_en) begin
         hc <= h_wrap ? '0 : hc + 1'b1;
         if (h_wrap) vc <= v_wrap ? '0 : vc + 1'b1;
         if (h_wrap && v_wrap) fc <= fc + 1'b1;
      end
   end
   assign blank = (hc < H_VIS) && (vc < V_VIS);
   assign hs    = !((hc >= HS_BEG) && (hc < HS_END));
   assign vs    = !((vc >= VS_BEG) && (vc < VS_END));
   vga_sync_delay #(.DEPTH(PIPE_DELAY), .WIDTH(3), .RST_VAL(3'b110)) u_delay (
      .vga_clk (vga_clk),
      .reset_n (reset_n),
      .d       ({hs, vs, blank}),
      .q       (dq)
   );
   assign vga.DrawX       = hc;
   assign vga.DrawY       = vc;
   assign vga.blank       = blank;
   assign vga.hs          = hs;
   assign vga.vs          = vs;
   assign vga.hs_d        = dq[2];
   assign vga.vs_d        = dq[1];
   assign vga.blank_d     = dq[0];
   assign vga.line_start  = reset_n && vga.pixel_en && (hc == '0);
   assign vga.frame_start = reset_n && vga.pixel_en && (hc == '0) && (vc == '0);
   assign vga.frame_count = fc;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: full-size and shrunk-geometry generators against an enabled-pixel-count model
module tb_vga_timing_gen;
   logic vga_clk = 1'b0;
   logic reset_n = 1'b0;
   logic pe = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   n = 0;
   logic [2:0] hist [3][4];
   int   gh [3][4] = '{'{640, 16, 96, 48}, '{8, 2, 3, 2}, '{8, 2, 3, 2}};
   int   gv [3][4] = '{'{480, 10, 2, 33}, '{6, 2, 2, 3}, '{6, 2, 2, 3}};
   int   dly [3] = '{1, 3, 0};
   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       blank;
      logic       hs;
      logic       vs;
      logic [7:0] fc;
   } exp_t;

   always #5 vga_clk = ~vga_clk;

   vga_timing_gen_if ia ();
   vga_timing_gen_if ib ();
   vga_timing_gen_if ic ();
   assign ia.pixel_en = pe;
   assign ib.pixel_en = pe;
   assign ic.pixel_en = pe;

   vga_timing_gen #(.PIPE_DELAY(1)) dut_a (.vga_clk(vga_clk), .reset_n(reset_n), .vga(ia));
   vga_timing_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .PIPE_DELAY(3))
      dut_b (.vga_clk(vga_clk), .reset_n(reset_n), .vga(ib));
   vga_timing_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .PIPE_DELAY(0))
      dut_c (.vga_clk(vga_clk), .reset_n(reset_n), .vga(ic));

   // position is a pure function of how many enabled pixels have elapsed since reset
   function automatic exp_t ref_at(int k, int m);
      exp_t e;
      int ht, vt, x, l, y, hs0, vs0;
      ht  = gh[k][0] + gh[k][1] + gh[k][2] + gh[k][3];
      vt  = gv[k][0] + gv[k][1] + gv[k][2] + gv[k][3];
      x   = m % ht;
      l   = m / ht;
      y   = l % vt;
      hs0 = gh[k][0] + gh[k][1];
      vs0 = gv[k][0] + gv[k][1];
      e.x     = 10'(x);
      e.y     = 10'(y);
      e.blank = (x < gh[k][0]) && (y < gv[k][0]);
      e.hs    = !(x >= hs0 && x < hs0 + gh[k][2]);
      e.vs    = !(y >= vs0 && y < vs0 + gv[k][2]);
      e.fc    = 8'((l / vt) % 256);
      return e;
   endfunction

   // model: history of undelayed syncs per clock, enabled-pixel count
   always @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         n = 0;
         for (int k = 0; k < 3; k++)
            for (int i = 0; i < 4; i++) hist[k][i] = 3'b110;
      end else begin
         for (int k = 0; k < 3; k++) begin
            exp_t e;
            e = ref_at(k, n);
            for (int i = 3; i > 0; i--) hist[k][i] = hist[k][i-1];
            hist[k][0] = {e.hs, e.vs, e.blank};
         end
         if (pe) n++;
      end
   end

   task automatic cmp(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s dut%0d got=%0h exp=%0h n=%0d", tag, k, got, exp, n);
      end
   endtask

   task automatic chk(input int k, input logic [9:0] x, input logic [9:0] y, input logic bl,
                      input logic h, input logic v, input logic hd, input logic vd, input logic bd,
                      input logic ls, input logic fs, input logic [7:0] fc);
      exp_t e;
      logic [2:0] d;
      e = ref_at(k, n);
      if (dly[k] == 0) d = {e.hs, e.vs, e.blank};
      else d = hist[k][dly[k]-1];
      cmp("DrawX", k, x, e.x);
      cmp("DrawY", k, y, e.y);
      cmp("blank", k, bl, e.blank);
      cmp("hs", k, h, e.hs);
      cmp("vs", k, v, e.vs);
      cmp("hs_d", k, hd, d[2]);
      cmp("vs_d", k, vd, d[1]);
      cmp("blank_d", k, bd, d[0]);
      cmp("line_start", k, ls, reset_n && pe && e.x == 0);
      cmp("frame_start", k, fs, reset_n && pe && e.x == 0 && e.y == 0);
      cmp("frame_count", k, fc, e.fc);
   endtask

   task automatic check_all();
      chk(0, ia.DrawX, ia.DrawY, ia.blank, ia.hs, ia.vs, ia.hs_d, ia.vs_d, ia.blank_d,
          ia.line_start, ia.frame_start, ia.frame_count);
      chk(1, ib.DrawX, ib.DrawY, ib.blank, ib.hs, ib.vs, ib.hs_d, ib.vs_d, ib.blank_d,
          ib.line_start, ib.frame_start, ib.frame_count);
      chk(2, ic.DrawX, ic.DrawY, ic.blank, ic.hs, ic.vs, ic.hs_d, ic.vs_d, ic.blank_d,
          ic.line_start, ic.frame_start, ic.frame_count);
   endtask

   task automatic step(input logic p);
      @(negedge vga_clk);
      check_all();
      pe = p;
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      #1;
      check_all();
      repeat (3) step(1'b1);
      reset_n = 1'b1;
   endtask

   initial begin
      exp_t e;
      bit found;
      repeat (3) step(1'b1);
      reset_n = 1'b1;
      repeat (1700) step(1'b1);
      repeat (2000) step(1'($urandom_range(0, 1)));
      for (int i = 0; i < 1000; i++) step(1'(i % 2));
      found = 0;
      for (int i = 0; i < 2000 && !found; i++) begin
         e = ref_at(0, n);
         if (e.x == 10'd700) found = 1;
         else step(1'b1);
      end
      checks++;
      if (!found) begin
         failures++;
         $error("FAIL wait_x700 never reached within bound");
      end
      pulse_reset();
      repeat (52000) step(1'b1);
      repeat (500) step(1'($urandom_range(0, 3) != 0));
      found = 0;
      for (int i = 0; i < 800 && !found; i++) begin
         e = ref_at(1, n);
         if (e.x >= 10 && e.x <= 12 && e.y >= 8 && e.y <= 9) found = 1;
         else step(1'b1);
      end
      checks++;
      if (!found) begin
         failures++;
         $error("FAIL wait_in_sync never reached within bound");
      end
      pulse_reset();
      repeat (600) step(1'($urandom_range(0, 1)));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
